// File: rtl/game_round_sequencer_pkg.sv
// Shared types and constants for the game round sequencer.
package game_round_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGen,
    StArm,
    StPlay,
    StJudge,
    StReport,
    StDone
  } state_e;

  // Largest score a two-digit BCD display can show.
  localparam int unsigned BcdMax = 99;

endpackage

// File: rtl/game_round_sequencer_bcd_score_accum.sv
// Two-digit BCD score register with digit-wise add and saturation at 99.
module game_round_sequencer_bcd_score_accum
  import game_round_sequencer_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       add_en_i,
  input  logic [6:0] add_val_i,
  output logic [3:0] d10_o,
  output logic [3:0] d1_o
);

  logic [3:0] d10_q, d10_d, d1_q, d1_d;
  logic [3:0] add_d10, add_d1;
  logic [4:0] ones_sum, tens_sum;

  // Next score: clear wins over add; carry out of the tens digit saturates.
  always_comb begin
    add_d10  = 4'(add_val_i / 7'd10);
    add_d1   = 4'(add_val_i % 7'd10);
    ones_sum = {1'b0, d1_q} + {1'b0, add_d1};
    tens_sum = {1'b0, d10_q} + {1'b0, add_d10};
    if (ones_sum > 5'd9) begin
      ones_sum = ones_sum - 5'd10;
      tens_sum = tens_sum + 5'd1;
    end
    d10_d = d10_q;
    d1_d  = d1_q;
    if (clr_i) begin
      d10_d = '0;
      d1_d  = '0;
    end else if (add_en_i) begin
      if (tens_sum > 5'd9) begin
        d10_d = 4'(BcdMax / 10);
        d1_d  = 4'(BcdMax % 10);
      end else begin
        d10_d = tens_sum[3:0];
        d1_d  = ones_sum[3:0];
      end
    end
  end

  // Score digit registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d10_q <= '0;
      d1_q  <= '0;
    end else begin
      d10_q <= d10_d;
      d1_q  <= d1_d;
    end
  end

  assign d10_o = d10_q;
  assign d1_o  = d1_q;

endmodule

// File: rtl/game_round_sequencer.sv
// Multi-round game controller: drives RNG/timer per round, accumulates a BCD score and
// hands it to Scoring with a req/ack handshake.
module game_round_sequencer
  import game_round_sequencer_pkg::*;
#(
  parameter int unsigned NumRounds  = 5,
  parameter int unsigned PtsCorrect = 10,
  parameter int unsigned RoundW     = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              logged_in_i,
  input  logic              start_pulse_i,
  input  logic              answer_pulse_i,
  input  logic              answer_correct_i,
  input  logic              timeout_i,
  input  logic              score_ack_i,
  output logic              rng_gen_o,
  output logic              timer_reconfig_o,
  output logic              timer_enable_o,
  output logic [RoundW-1:0] round_num_o,
  output logic [3:0]        score_d10_o,
  output logic [3:0]        score_d1_o,
  output logic              score_req_o,
  output logic              busy_o,
  output logic              game_done_o
);

  state_e            state_q;
  logic [RoundW-1:0] round_q;
  logic              hit_q;
  logic              start_ok, logout, score_clr, score_add;

  assign start_ok  = start_pulse_i & logged_in_i & ((state_q == StIdle) || (state_q == StDone));
  // Losing the session aborts everything, including a pending score request.
  assign logout    = ~logged_in_i & (state_q != StIdle);
  assign score_clr = start_ok | logout;
  assign score_add = (state_q == StJudge) & hit_q;

  game_round_sequencer_bcd_score_accum u_score (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (score_clr),
    .add_en_i  (score_add),
    .add_val_i (7'(PtsCorrect)),
    .d10_o     (score_d10_o),
    .d1_o      (score_d1_o)
  );

  // Round FSM plus round counter and latched answer result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      round_q <= '0;
      hit_q   <= 1'b0;
    end else if (logout) begin
      state_q <= StIdle;
      round_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start_ok) begin
            state_q <= StGen;
            round_q <= RoundW'(1);
          end
        end
        StGen:   state_q <= StArm;
        StArm:   state_q <= StPlay;
        StPlay: begin
          // An answer in the same cycle as a timeout takes priority.
          if (answer_pulse_i) begin
            hit_q   <= answer_correct_i;
            state_q <= StJudge;
          end else if (timeout_i) begin
            hit_q   <= 1'b0;
            state_q <= StJudge;
          end
        end
        StJudge: begin
          if (round_q == RoundW'(NumRounds)) begin
            state_q <= StReport;
          end else begin
            round_q <= round_q + RoundW'(1);
            state_q <= StGen;
          end
        end
        StReport: begin
          if (score_ack_i) state_q <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rng_gen_o        = (state_q == StGen);
  assign timer_reconfig_o = (state_q == StArm);
  assign timer_enable_o   = (state_q == StPlay);
  assign score_req_o      = (state_q == StReport);
  assign game_done_o      = (state_q == StDone);
  assign busy_o           = (state_q != StIdle) && (state_q != StDone);
  assign round_num_o      = round_q;

endmodule

// File: tb/tb_game_round_sequencer.sv
// Self-checking bench: two sequencers (10 and 30 points per hit) share one stimulus stream;
// expected outputs come from a round/score model using plain integer arithmetic.
module tb_game_round_sequencer;
  localparam int unsigned NumRounds = 5;
  localparam int unsigned RoundW    = 4;

  logic clk, rst_n, logged_in, start_p, answer_p, answer_c, timeout, ack;
  logic rng_a, rcfg_a, ten_a, req_a, busy_a, done_a;
  logic rng_b, rcfg_b, ten_b, req_b, busy_b, done_b;
  logic [RoundW-1:0] round_a, round_b;
  logic [3:0] d10_a, d1_a, d10_b, d1_b;

  int vectors = 0;
  int errs    = 0;
  int exp_round, exp_a, exp_b;

  game_round_sequencer #(.NumRounds(NumRounds), .PtsCorrect(10), .RoundW(RoundW)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .logged_in_i(logged_in), .start_pulse_i(start_p),
    .answer_pulse_i(answer_p), .answer_correct_i(answer_c), .timeout_i(timeout),
    .score_ack_i(ack), .rng_gen_o(rng_a), .timer_reconfig_o(rcfg_a), .timer_enable_o(ten_a),
    .round_num_o(round_a), .score_d10_o(d10_a), .score_d1_o(d1_a), .score_req_o(req_a),
    .busy_o(busy_a), .game_done_o(done_a)
  );

  game_round_sequencer #(.NumRounds(NumRounds), .PtsCorrect(30), .RoundW(RoundW)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .logged_in_i(logged_in), .start_pulse_i(start_p),
    .answer_pulse_i(answer_p), .answer_correct_i(answer_c), .timeout_i(timeout),
    .score_ack_i(ack), .rng_gen_o(rng_b), .timer_reconfig_o(rcfg_b), .timer_enable_o(ten_b),
    .round_num_o(round_b), .score_d10_o(d10_b), .score_d1_o(d1_b), .score_req_o(req_b),
    .busy_o(busy_b), .game_done_o(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic rng, input logic rcfg, input logic ten,
                         input logic req, input logic busy, input logic done);
    chk({tag, ".rng_a"}, 32'(rng_a), 32'(rng));
    chk({tag, ".rcfg_a"}, 32'(rcfg_a), 32'(rcfg));
    chk({tag, ".ten_a"}, 32'(ten_a), 32'(ten));
    chk({tag, ".req_a"}, 32'(req_a), 32'(req));
    chk({tag, ".busy_a"}, 32'(busy_a), 32'(busy));
    chk({tag, ".done_a"}, 32'(done_a), 32'(done));
    chk({tag, ".round_a"}, 32'(round_a), 32'(exp_round));
    chk({tag, ".rng_b"}, 32'(rng_b), 32'(rng));
    chk({tag, ".rcfg_b"}, 32'(rcfg_b), 32'(rcfg));
    chk({tag, ".ten_b"}, 32'(ten_b), 32'(ten));
    chk({tag, ".req_b"}, 32'(req_b), 32'(req));
    chk({tag, ".busy_b"}, 32'(busy_b), 32'(busy));
    chk({tag, ".done_b"}, 32'(done_b), 32'(done));
    chk({tag, ".round_b"}, 32'(round_b), 32'(exp_round));
  endtask

  task automatic chk_score(input string tag);
    chk({tag, ".d10_a"}, 32'(d10_a), 32'(exp_a / 10));
    chk({tag, ".d1_a"}, 32'(d1_a), 32'(exp_a % 10));
    chk({tag, ".d10_b"}, 32'(d10_b), 32'(exp_b / 10));
    chk({tag, ".d1_b"}, 32'(d1_b), 32'(exp_b % 10));
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    start_p  = 1'b0;
    answer_p = 1'b0;
    timeout  = 1'b0;
    ack      = 1'b0;
  endtask

  task automatic exp_idle(input string tag);
    exp_round = 0;
    chk_ctl(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_score(tag);
  endtask

  task automatic start_game();
    start_p = 1'b1;
    tick();
    exp_round = 1;
    exp_a     = 0;
    exp_b     = 0;
    chk_ctl("gen", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_score("gen");
  endtask

  // mode: 0 answer only, 1 timeout only, 2 answer and timeout together. Starts in GEN.
  task automatic play_round(input int mode, input logic corr, input int waits);
    bit hit;
    tick();
    chk_ctl("arm", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_ctl("play", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < waits; i++) begin
      start_p  = 1'($urandom_range(0, 1));
      ack      = 1'($urandom_range(0, 1));
      answer_c = 1'($urandom_range(0, 1));
      tick();
      chk_ctl("play_wait", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    answer_c = corr;
    answer_p = (mode != 1);
    timeout  = (mode != 0);
    hit      = (mode != 1) && corr;
    tick();
    chk_ctl("judge", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_score("judge_hold");
    if (hit) begin
      exp_a = (exp_a + 10 > 99) ? 99 : exp_a + 10;
      exp_b = (exp_b + 30 > 99) ? 99 : exp_b + 30;
    end
    tick();
    if (exp_round == NumRounds) begin
      chk_ctl("report", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    end else begin
      exp_round++;
      chk_ctl("next_gen", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk_score("after_judge");
  endtask

  // Starts in the first REPORT cycle; ack after 'delay' extra cycles.
  task automatic report_ack(input int delay);
    for (int i = 0; i < delay; i++) begin
      answer_p = 1'b1;
      timeout  = 1'b1;
      tick();
      chk_ctl("report_hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk_score("report_hold");
    end
    ack = 1'b1;
    tick();
    chk_ctl("done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_score("done");
  endtask

  initial begin
    rst_n     = 1'b0;
    logged_in = 1'b0;
    start_p   = 1'b0;
    answer_p  = 1'b0;
    answer_c  = 1'b0;
    timeout   = 1'b0;
    ack       = 1'b0;
    exp_round = 0;
    exp_a     = 0;
    exp_b     = 0;
    #12;
    exp_idle("reset");
    tick();
    rst_n = 1'b1;
    tick();
    exp_idle("post_reset");

    // Start without a session and stray strobes in IDLE are ignored.
    start_p  = 1'b1;
    answer_p = 1'b1;
    timeout  = 1'b1;
    ack      = 1'b1;
    tick();
    exp_idle("idle_stray");
    logged_in = 1'b1;
    tick();
    exp_idle("idle_login");

    // Five correct answers: 50 and 30,60,90,99,99.
    start_game();
    for (int r = 0; r < NumRounds; r++) play_round(0, 1'b1, 0);
    chk("five_correct_a", 32'(exp_a), 32'd50);
    chk("five_correct_b", 32'(exp_b), 32'd99);
    report_ack(0);

    // Stray inputs in DONE leave state and score untouched.
    answer_p = 1'b1;
    timeout  = 1'b1;
    ack      = 1'b1;
    tick();
    chk_ctl("done_stray", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_score("done_stray");

    // Mixed outcomes, including answer+timeout collision and a slow ack.
    start_game();
    play_round(0, 1'b1, 1);
    play_round(2, 1'b1, 0);
    play_round(1, 1'b1, 2);
    play_round(0, 1'b0, 0);
    play_round(2, 1'b0, 3);
    report_ack(7);

    // Randomised games back to back from DONE.
    for (int g = 0; g < 4; g++) begin
      start_game();
      for (int r = 0; r < NumRounds; r++)
        play_round(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)));
      report_ack(int'($urandom_range(0, 4)));
    end

    // Losing the session in REPORT withdraws the request and clears the score.
    start_game();
    for (int r = 0; r < NumRounds; r++) play_round(0, 1'b1, 0);
    logged_in = 1'b0;
    tick();
    exp_a = 0;
    exp_b = 0;
    exp_idle("logout_report");
    start_p = 1'b1;
    tick();
    exp_idle("start_no_login");
    logged_in = 1'b1;
    tick();
    exp_idle("relogin_idle");

    // Asynchronous reset in the middle of PLAY.
    start_game();
    play_round(0, 1'b1, 0);
    tick();
    tick();
    chk_ctl("pre_reset_play", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    exp_a = 0;
    exp_b = 0;
    exp_idle("async_reset");
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    exp_idle("after_reset_wait");
    start_game();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
